// File: rtl/pwm_phase_gen_if.sv
// Settings/status bundle between the channel's control source and pwm_phase_gen.
// With PWM_PHASE_GEN_POL_EN defined, the bundle also carries the pwm_pol_i polarity bit.
interface pwm_phase_gen_if #(
    parameter int PWM_CNT_WIDTH = 24
);
    logic                     pwm_en_i;
    logic [PWM_CNT_WIDTH-1:0] pwm_period_i;
    logic [PWM_CNT_WIDTH-1:0] pwm_duty_i;
    logic [PWM_CNT_WIDTH-1:0] phase_static_i;
    logic                     phase_sel_i;
    logic [PWM_CNT_WIDTH-1:0] phase_fsm_i;
`ifdef PWM_PHASE_GEN_POL_EN
    logic                     pwm_pol_i;
`endif
    logic                     pwm_sig_o;
    logic [PWM_CNT_WIDTH-1:0] pwm_cnt_o;
    logic                     pwm_wrap_o;
    logic                     pwm_upd_o;

`ifdef PWM_PHASE_GEN_POL_EN
    modport master (
        output pwm_en_i, pwm_period_i, pwm_duty_i, phase_static_i, phase_sel_i, phase_fsm_i,
        output pwm_pol_i,
        input  pwm_sig_o, pwm_cnt_o, pwm_wrap_o, pwm_upd_o
    );
    modport slave (
        input  pwm_en_i, pwm_period_i, pwm_duty_i, phase_static_i, phase_sel_i, phase_fsm_i,
        input  pwm_pol_i,
        output pwm_sig_o, pwm_cnt_o, pwm_wrap_o, pwm_upd_o
    );
`else
    modport master (
        output pwm_en_i, pwm_period_i, pwm_duty_i, phase_static_i, phase_sel_i, phase_fsm_i,
        input  pwm_sig_o, pwm_cnt_o, pwm_wrap_o, pwm_upd_o
    );
    modport slave (
        input  pwm_en_i, pwm_period_i, pwm_duty_i, phase_static_i, phase_sel_i, phase_fsm_i,
        output pwm_sig_o, pwm_cnt_o, pwm_wrap_o, pwm_upd_o
    );
`endif
endinterface

// File: rtl/pwm_phase_gen.sv
// Single-channel phase-offset PWM generator; all settings are shadowed and applied at period wrap.
// Optional output polarity: define PWM_PHASE_GEN_POL_EN.
module pwm_phase_gen #(
    parameter int PWM_CNT_WIDTH = 24
) (
    input  logic           axi_clk,
    input  logic           axi_rstn,
    pwm_phase_gen_if.slave pwm_if
);
    localparam int W = PWM_CNT_WIDTH;

    typedef enum logic {
        ST_DIS = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   sh_period_q, sh_period_d;
    logic [W-1:0]   sh_duty_q, sh_duty_d;
    logic [W-1:0]   sh_phase_q, sh_phase_d;
    logic           sig_q, sig_d;
    logic           upd_q, upd_d;

    logic           load;
    logic           wrap;
    logic [W-1:0]   phase_mux;
    logic [W-1:0]   phase_clamped;
    logic [W:0]     rel_raw;
    logic [W:0]     rel;
    logic           in_window;
    logic           cmp_out;
    logic           pol_in;
    logic           pol_cur;

`ifdef PWM_PHASE_GEN_POL_EN
    logic           sh_pol_q, sh_pol_d;

    assign pol_in  = pwm_if.pwm_pol_i;
    assign pol_cur = sh_pol_q;
`else
    assign pol_in  = 1'b0;
    assign pol_cur = 1'b0;
`endif

    // Phase source is picked here but only reaches the shadow set at a load edge.
    assign phase_mux     = pwm_if.phase_sel_i ? pwm_if.phase_fsm_i : pwm_if.phase_static_i;
    assign phase_clamped = (phase_mux > pwm_if.pwm_period_i) ? pwm_if.pwm_period_i : phase_mux;

    assign wrap = (state_q == ST_RUN) && (cnt_q == sh_period_q);

    // Position inside the phase-shifted window, folded back into 0..period when it goes negative.
    always_comb begin
        rel_raw = {1'b0, cnt_q} - {1'b0, sh_phase_q};
        rel     = rel_raw;
        if (rel_raw[W]) begin
            rel = rel_raw + {1'b0, sh_period_q} + (W+1)'(1);
        end
    end

    assign in_window = (rel < {1'b0, sh_duty_q});
    assign cmp_out   = in_window ^ pol_cur;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        sh_phase_d  = sh_phase_q;
        sig_d       = sig_q;
        upd_d       = 1'b0;
        load        = 1'b0;
`ifdef PWM_PHASE_GEN_POL_EN
        sh_pol_d    = sh_pol_q;
`endif

        case (state_q)
            ST_DIS: begin
                cnt_d = '0;
                sig_d = pol_cur;
                if (pwm_if.pwm_en_i) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                    sig_d   = pol_in;
                end
            end
            ST_RUN: begin
                if (!pwm_if.pwm_en_i) begin
                    // Disable beats a coincident wrap: no reload, no update pulse.
                    state_d = ST_DIS;
                    cnt_d   = '0;
                    sig_d   = pol_cur;
                end else begin
                    sig_d = cmp_out;
                    if (wrap) begin
                        cnt_d = '0;
                        load  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_DIS;
                cnt_d   = '0;
                sig_d   = 1'b0;
            end
        endcase

        if (load) begin
            sh_period_d = pwm_if.pwm_period_i;
            sh_duty_d   = pwm_if.pwm_duty_i;
            sh_phase_d  = phase_clamped;
            upd_d       = 1'b1;
`ifdef PWM_PHASE_GEN_POL_EN
            sh_pol_d    = pol_in;
`endif
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q     <= ST_DIS;
            cnt_q       <= '0;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            sh_phase_q  <= '0;
            sig_q       <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            sh_phase_q  <= sh_phase_d;
            sig_q       <= sig_d;
            upd_q       <= upd_d;
        end
    end

`ifdef PWM_PHASE_GEN_POL_EN
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            sh_pol_q <= 1'b0;
        end else begin
            sh_pol_q <= sh_pol_d;
        end
    end
`endif

    assign pwm_if.pwm_sig_o  = sig_q;
    assign pwm_if.pwm_cnt_o  = cnt_q;
    assign pwm_if.pwm_wrap_o = wrap;
    assign pwm_if.pwm_upd_o  = upd_q;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed self-checking bench for pwm_phase_gen; expected waveforms are hand-written per-count masks.
module tb_pwm_phase_gen;
    localparam int W = 24;

    logic axi_clk;
    logic axi_rstn;
    int   total;
    int   bad;

    pwm_phase_gen_if #(.PWM_CNT_WIDTH(W)) bus ();

    pwm_phase_gen #(.PWM_CNT_WIDTH(W)) dut (
        .axi_clk  (axi_clk),
        .axi_rstn (axi_rstn),
        .pwm_if   (bus.slave)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic configure(input int period, input int duty, input int ph_static,
                             input logic sel, input int ph_fsm);
        bus.pwm_period_i   = W'(period);
        bus.pwm_duty_i     = W'(duty);
        bus.phase_static_i = W'(ph_static);
        bus.phase_sel_i    = sel;
        bus.phase_fsm_i    = W'(ph_fsm);
    endtask

    task automatic test_reset();
        axi_rstn = 1'b0;
        bus.pwm_en_i = 1'b0;
        configure(0, 0, 0, 1'b0, 0);
`ifdef PWM_PHASE_GEN_POL_EN
        bus.pwm_pol_i = 1'b0;
`endif
        #1;
        total += 4;
        if (bus.pwm_sig_o !== 1'b0)  begin bad++; $display("FAIL reset sig got=%b exp=0", bus.pwm_sig_o); end
        if (bus.pwm_cnt_o !== '0)    begin bad++; $display("FAIL reset cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_wrap_o !== 1'b0) begin bad++; $display("FAIL reset wrap got=%b exp=0", bus.pwm_wrap_o); end
        if (bus.pwm_upd_o !== 1'b0)  begin bad++; $display("FAIL reset upd got=%b exp=0", bus.pwm_upd_o); end
        tick();
        tick();
        @(negedge axi_clk);
        axi_rstn = 1'b1;
        tick();
        total += 2;
        if (bus.pwm_cnt_o !== '0)   begin bad++; $display("FAIL idle cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_upd_o !== 1'b0) begin bad++; $display("FAIL idle upd got=%b exp=0", bus.pwm_upd_o); end
        $display("reset: done");
    endtask

    // Enable with the current settings and check the first RUN cycle, then run n cycles against mask.
    task automatic run_mask(input string name, input logic [9:0] mask, input int n);
        logic [W-1:0] ec;
        logic         es;
        bus.pwm_en_i = 1'b1;
        tick();
        total += 3;
        if (bus.pwm_cnt_o !== '0)   begin bad++; $display("FAIL %s first cnt got=%0d exp=0", name, bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b0) begin bad++; $display("FAIL %s first sig got=%b exp=0", name, bus.pwm_sig_o); end
        if (bus.pwm_upd_o !== 1'b1) begin bad++; $display("FAIL %s first upd got=%b exp=1", name, bus.pwm_upd_o); end
        for (int i = 1; i <= n; i++) begin
            tick();
            ec = W'(i % 10);
            es = mask[(i - 1) % 10];
            total += 4;
            if (bus.pwm_cnt_o !== ec) begin
                bad++; $display("FAIL %s cnt i=%0d got=%0d exp=%0d", name, i, bus.pwm_cnt_o, ec);
            end
            if (bus.pwm_sig_o !== es) begin
                bad++; $display("FAIL %s sig i=%0d got=%b exp=%b", name, i, bus.pwm_sig_o, es);
            end
            if (bus.pwm_wrap_o !== (ec == W'(9))) begin
                bad++; $display("FAIL %s wrap i=%0d got=%b exp=%b", name, i, bus.pwm_wrap_o, (ec == W'(9)));
            end
            if (bus.pwm_upd_o !== (i % 10 == 0)) begin
                bad++; $display("FAIL %s upd i=%0d got=%b exp=%b", name, i, bus.pwm_upd_o, (i % 10 == 0));
            end
        end
        bus.pwm_en_i = 1'b0;
        tick();
        total += 2;
        if (bus.pwm_cnt_o !== '0)   begin bad++; $display("FAIL %s off cnt got=%0d exp=0", name, bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b0) begin bad++; $display("FAIL %s off sig got=%b exp=0", name, bus.pwm_sig_o); end
        $display("%s: period=%0d duty=%0d mask=%b done", name, bus.pwm_period_i, bus.pwm_duty_i, mask);
    endtask

    task automatic test_basic_duty();
        configure(9, 3, 0, 1'b0, 0);
        run_mask("basic", 10'b0000000111, 20);
    endtask

    task automatic test_wrap_phase();
        configure(9, 3, 8, 1'b0, 0);
        run_mask("phase8", 10'b1100000001, 20);
        configure(9, 3, 15, 1'b0, 0);
        run_mask("phase15", 10'b1000000011, 20);
        configure(9, 3, 0, 1'b1, 12);
        run_mask("fsm12", 10'b1000000011, 10);
    endtask

    task automatic test_deferred_update();
        logic [9:0] old_mask;
        logic [9:0] new_mask;
        logic       es;
        old_mask = 10'b0000000111;
        new_mask = 10'b0011111100;
        configure(9, 3, 0, 1'b1, 0);
        bus.pwm_en_i = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 4) begin
                bus.pwm_duty_i  = W'(6);
                bus.phase_fsm_i = W'(2);
            end
            es = (i <= 10) ? old_mask[(i - 1) % 10] : new_mask[(i - 1) % 10];
            total += 2;
            if (bus.pwm_sig_o !== es) begin
                bad++; $display("FAIL deferred sig i=%0d got=%b exp=%b", i, bus.pwm_sig_o, es);
            end
            if (bus.pwm_upd_o !== (i == 10 || i == 20)) begin
                bad++; $display("FAIL deferred upd i=%0d got=%b exp=%b", i, bus.pwm_upd_o, (i == 10 || i == 20));
            end
        end
        bus.pwm_en_i = 1'b0;
        tick();
        $display("deferred: done");
    endtask

    task automatic test_extremes();
        configure(9, 0, 0, 1'b0, 0);
        run_mask("duty0", 10'b0000000000, 12);
        configure(9, 10, 3, 1'b0, 0);
        run_mask("duty10", 10'b1111111111, 12);
        configure(0, 1, 0, 1'b0, 0);
        bus.pwm_en_i = 1'b1;
        tick();
        total += 2;
        if (bus.pwm_wrap_o !== 1'b1) begin bad++; $display("FAIL p0 first wrap got=%b exp=1", bus.pwm_wrap_o); end
        if (bus.pwm_sig_o !== 1'b0)  begin bad++; $display("FAIL p0 first sig got=%b exp=0", bus.pwm_sig_o); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total += 4;
            if (bus.pwm_cnt_o !== '0)    begin bad++; $display("FAIL p0 cnt i=%0d got=%0d exp=0", i, bus.pwm_cnt_o); end
            if (bus.pwm_sig_o !== 1'b1)  begin bad++; $display("FAIL p0 sig i=%0d got=%b exp=1", i, bus.pwm_sig_o); end
            if (bus.pwm_wrap_o !== 1'b1) begin bad++; $display("FAIL p0 wrap i=%0d got=%b exp=1", i, bus.pwm_wrap_o); end
            if (bus.pwm_upd_o !== 1'b1)  begin bad++; $display("FAIL p0 upd i=%0d got=%b exp=1", i, bus.pwm_upd_o); end
        end
        bus.pwm_en_i = 1'b0;
        tick();
        $display("period0: done");
    endtask

    task automatic test_disable_reset();
        configure(9, 6, 0, 1'b0, 0);
        bus.pwm_en_i = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) tick();
        total += 2;
        if (bus.pwm_cnt_o !== W'(5)) begin bad++; $display("FAIL dis pre cnt got=%0d exp=5", bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b1)  begin bad++; $display("FAIL dis pre sig got=%b exp=1", bus.pwm_sig_o); end
        bus.pwm_en_i = 1'b0;
        tick();
        total += 3;
        if (bus.pwm_cnt_o !== '0)   begin bad++; $display("FAIL dis cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b0) begin bad++; $display("FAIL dis sig got=%b exp=0", bus.pwm_sig_o); end
        if (bus.pwm_upd_o !== 1'b0) begin bad++; $display("FAIL dis upd got=%b exp=0", bus.pwm_upd_o); end
        bus.pwm_en_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        total += 2;
        if (bus.pwm_cnt_o !== W'(3)) begin bad++; $display("FAIL reen cnt got=%0d exp=3", bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b1)  begin bad++; $display("FAIL reen sig got=%b exp=1", bus.pwm_sig_o); end
        #2;
        axi_rstn = 1'b0;
        #1;
        total += 3;
        if (bus.pwm_sig_o !== 1'b0)  begin bad++; $display("FAIL arst sig got=%b exp=0", bus.pwm_sig_o); end
        if (bus.pwm_cnt_o !== '0)    begin bad++; $display("FAIL arst cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_wrap_o !== 1'b0) begin bad++; $display("FAIL arst wrap got=%b exp=0", bus.pwm_wrap_o); end
        @(negedge axi_clk);
        @(negedge axi_clk);
        axi_rstn = 1'b1;
        tick();
        tick();
        total += 2;
        if (bus.pwm_cnt_o !== W'(1)) begin bad++; $display("FAIL post-rst cnt got=%0d exp=1", bus.pwm_cnt_o); end
        if (bus.pwm_sig_o !== 1'b1)  begin bad++; $display("FAIL post-rst sig got=%b exp=1", bus.pwm_sig_o); end
        bus.pwm_en_i = 1'b0;
        tick();
        $display("disable/reset: done");
    endtask

    task automatic test_disable_at_wrap();
        configure(4, 2, 0, 1'b0, 0);
        bus.pwm_en_i = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) tick();
        total += 2;
        if (bus.pwm_cnt_o !== W'(4)) begin bad++; $display("FAIL dwrap pre cnt got=%0d exp=4", bus.pwm_cnt_o); end
        if (bus.pwm_wrap_o !== 1'b1) begin bad++; $display("FAIL dwrap pre wrap got=%b exp=1", bus.pwm_wrap_o); end
        configure(7, 5, 0, 1'b0, 0);
        bus.pwm_en_i = 1'b0;
        tick();
        total += 3;
        if (bus.pwm_upd_o !== 1'b0)  begin bad++; $display("FAIL dwrap upd got=%b exp=0", bus.pwm_upd_o); end
        if (bus.pwm_cnt_o !== '0)    begin bad++; $display("FAIL dwrap cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_wrap_o !== 1'b0) begin bad++; $display("FAIL dwrap wrap got=%b exp=0", bus.pwm_wrap_o); end
        tick();
        total += 2;
        if (bus.pwm_cnt_o !== '0)   begin bad++; $display("FAIL dwrap hold cnt got=%0d exp=0", bus.pwm_cnt_o); end
        if (bus.pwm_upd_o !== 1'b0) begin bad++; $display("FAIL dwrap hold upd got=%b exp=0", bus.pwm_upd_o); end
        $display("disable at wrap: done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_duty();
        test_wrap_phase();
        test_deferred_update();
        test_extremes();
        test_disable_reset();
        test_disable_at_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
